dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, the number of extra wait cycles inserted before a response (legal 0..15).
REQ-002 SHALL have parameter DEPTH, default 256, the number of 32-bit words stored (equal to 2^8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  input  1  core requests a data access.
REQ-006 SHALL have port mem_write  input  1  1 = write, 0 = read; sampled with mem_req.
REQ-007 SHALL have port d_addr  input  8  word address.
REQ-008 SHALL have port dw_data  input  32  write data.
REQ-009 SHALL have port mem_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port mem_rvalid  output  1  one-cycle completion strobe for reads and writes.
REQ-011 SHALL have port dr_data  output  32  read data, valid when mem_rvalid=1 for a read.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 IDLE: mem_ready=1. A request is accepted on the edge where mem_req=1 and mem_ready=1; d_addr, mem_write and dw_data SHALL be captured on that edge.
REQ-014 On acceptance, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0. It SHALL go directly to RESP if WAIT_CYCLES=0.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-016 A write SHALL commit to the array on the edge that enters RESP. A read SHALL load dr_data from the array on that same edge.
REQ-017 RESP: mem_rvalid=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 If acceptance occurs in cycle k, mem_rvalid SHALL be high in cycle k+1+WAIT_CYCLES, giving a throughput of 1 request per WAIT_CYCLES+2 cycles.
REQ-019 mem_ready SHALL be 0 in WAIT and RESP. mem_req during those states SHALL be ignored and not queued.
REQ-020 dr_data SHALL hold its last read value across writes and idle cycles.
REQ-021 A read immediately following a write to the same address SHALL return the newly written data.
REQ-022 Address wrap: d_addr 8'hFF SHALL be a valid last word. There is no out-of-range case.

Reset
REQ-023 While rst=1: FSM=IDLE, counter=0, mem_ready=1, mem_rvalid=0, dr_data=32'h0.
REQ-024 Array contents SHALL NOT be reset.
REQ-025 Reset asserted in WAIT SHALL abort the access: no array write, no mem_rvalid pulse.

Configuration
REQ-026 Macro DMEM_BYTE_WRITE_EN: when defined, an added input mem_be[3:0] SHALL be captured with the request, and only bytes whose strobe is 1 SHALL be written. Reads SHALL ignore mem_be.
REQ-027 Without DMEM_BYTE_WRITE_EN, the mem_be port SHALL be absent and every write SHALL update all 32 bits.

Structure
REQ-028 Package dmem_pkg SHALL hold ADDR_W=8, DATA_W=32, DEPTH_DEFAULT=256, and the FSM state typedef (IDLE, WAIT, RESP).
REQ-029 Storage SHALL be a sub-module dmem_array: synchronous write with optional byte enables, synchronous read, no reset. The FSM and capture registers stay in dmem_responder.

Verification
REQ-030 Reset then idle -> mem_ready=1, mem_rvalid=0, dr_data=0.
REQ-031 WAIT_CYCLES=1: write 0xDEADBEEF to addr 0x10 accepted in cycle k -> mem_rvalid in cycle k+2 only. Then read 0x10 -> dr_data=0xDEADBEEF with mem_rvalid 2 cycles after acceptance.
REQ-032 WAIT_CYCLES=0: back-to-back reads of 0x00 and 0xFF with mem_req held high -> accepted every 2 cycles, each mem_rvalid exactly one cycle after its acceptance.
REQ-033 mem_req held high through WAIT with changing d_addr -> only the first address is serviced and no extra mem_rvalid occurs.
REQ-034 rst pulsed during WAIT of a write of 0x12345678 to 0x20 -> no mem_rvalid. A subsequent read of 0x20 returns the prior contents.
REQ-035 DMEM_BYTE_WRITE_EN defined: word 0x20 = 0xFFFFFFFF, write 0x00000000 with mem_be=4'b0101 -> read returns 0xFF00FF00.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, default depth and FSM state type for the data
// memory responder.
//   ADDR_W        word address width (8 -> 256 words)
//   DATA_W        word width in bits
//   BE_W          number of byte strobes per word
//   CNT_W         wait counter width (WAIT_CYCLES legal range 0..15)
//   DEPTH_DEFAULT default number of stored words
//   state_e       responder FSM states IDLE / WAIT / RESP
package dmem_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 32;
  localparam int BE_W          = DATA_W / 8;
  localparam int CNT_W         = 4;
  localparam int DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage with synchronous byte-strobed write and
// synchronous read. Contents are never reset.
// Ports:
//   clk      rising-edge clock
//   we       write enable; bytes with be[b]=1 are updated at the edge
//   re       read enable; rd_data loads mem[addr] at the edge and holds
//            its value on all other edges
//   addr     word address
//   wdata    write data
//   be       byte strobes for writes (ignored for reads)
//   rd_data  registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder for a core.
// A request is accepted in IDLE, optionally held for WAIT_CYCLES cycles in
// WAIT, then performed on the edge entering RESP; RESP raises mem_rvalid for
// one cycle and the FSM returns to IDLE.
//
// Handshake: a request transfers on a rising edge where mem_req=1 and
// mem_ready=1. mem_ready is high only in IDLE; requests seen while it is low
// are dropped, not queued. mem_rvalid is a one-cycle completion strobe for
// both reads and writes; dr_data is meaningful when it accompanies a read
// and otherwise holds the last read value.
//
// Parameters:
//   WAIT_CYCLES  extra wait cycles before the response (0..15)
//   DEPTH        number of 32-bit words stored
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   mem_req      request strobe
//   mem_write    1 = write, 0 = read
//   d_addr       word address
//   dw_data      write data
//   mem_be       byte strobes (present only with DMEM_BYTE_WRITE_EN)
//   mem_ready    responder can accept a request this cycle
//   mem_rvalid   completion strobe
//   dr_data      read data
//   dbg_state    current FSM state, for observation
// Configuration: define DMEM_BYTE_WRITE_EN to add mem_be and byte-granular
// writes; without it every write updates the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] dw_data,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [BE_W-1:0]   mem_be,
`endif
  output logic              mem_ready,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] dr_data,
  output state_e            dbg_state
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_seen_q, rd_seen_d;

  logic              accept;
  logic              enter_resp;
  logic              access_go;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [BE_W-1:0]   in_be;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rd_data;

`ifdef DMEM_BYTE_WRITE_EN
  assign in_be = mem_be;
`else
  assign in_be = '1;
`endif

  assign accept = mem_req && (state_q == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (accept) begin
      addr_d  = d_addr;
      write_d = mem_write;
      wdata_d = dw_data;
      be_d    = in_be;
    end
  end

  // The array is accessed on the edge that enters RESP. With zero wait
  // cycles that is the acceptance edge itself, so the operands come straight
  // from the inputs rather than from the capture registers.
  always_comb begin
    enter_resp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                 ((state_q == WAIT) && (cnt_q == '0));
    access_go  = enter_resp && !rst;
    if (state_q == IDLE) begin
      acc_write = mem_write;
      acc_addr  = d_addr;
      acc_wdata = dw_data;
      acc_be    = in_be;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    arr_we    = access_go && acc_write;
    arr_re    = access_go && !acc_write;
    // The array read register is not reset; this flag masks it to zero
    // until the first read after reset lands.
    rd_seen_d = rd_seen_q || arr_re;
  end

  // Outputs
  always_comb begin
    mem_ready  = (state_q == IDLE);
    mem_rvalid = (state_q == RESP);
    dr_data    = rd_seen_q ? arr_rd_data : '0;
    dbg_state  = state_q;
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .re      (arr_re),
    .addr    (acc_addr),
    .wdata   (acc_wdata),
    .be      (acc_be),
    .rd_data (arr_rd_data)
  );

endmodule
